// File: rtl/wm_drive_sequencer.sv
// Washing machine actuator sequencer.
// Turns the controller's one-hot phase flags and the drum sensors into valve,
// motor and door-lock drive. Agitation alternates direction with motor-off
// gaps between bursts. Fill and drain are time-limited. Faults latch until
// cleared while the controller is idle.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// OFF      | idle, every output low
// FILL     | inlet open, waiting for level_full (fill timeout armed)
// HOLD     | soak with a full drum, door locked only
// AGIT_FWD | forward agitation burst, AGIT_ON cycles
// DEAD_F   | motor off after a forward burst, AGIT_DEAD cycles
// AGIT_REV | reverse agitation burst, AGIT_ON cycles
// DEAD_R   | motor off after a reverse burst, AGIT_DEAD cycles
// DRAIN    | drain open, waiting for level_empty (drain timeout armed)
// SPIN     | fast forward spin with the drain open
// STOP     | motor-off run-down before OFF, AGIT_DEAD cycles
// FAULT    | safety drain, door unlocked, fault code latched
module wm_drive_sequencer #(
  parameter int AGIT_ON   = 4,
  parameter int AGIT_DEAD = 2,
  parameter int FILL_TMO  = 20,
  parameter int DRAIN_TMO = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       soak_op,
  input  logic       wash_op,
  input  logic       rinse_op,
  input  logic       spin_op,
  input  logic       water_inlet,
  input  logic       lid,
  input  logic       level_full,
  input  logic       level_empty,
  input  logic       fault_clr,
  output logic       inlet_valve,
  output logic       drain_valve,
  output logic       motor_fwd,
  output logic       motor_rev,
  output logic       motor_fast,
  output logic       door_lock,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam int MAX_AD  = (AGIT_ON > AGIT_DEAD) ? AGIT_ON : AGIT_DEAD;
  localparam int MAX_FD  = (FILL_TMO > DRAIN_TMO) ? FILL_TMO : DRAIN_TMO;
  localparam int MAX_ALL = (MAX_AD > MAX_FD) ? MAX_AD : MAX_FD;
  localparam int CNT_W   = $clog2(MAX_ALL + 1);

  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(AGIT_ON - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST  = CNT_W'(AGIT_DEAD - 1);
  localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(FILL_TMO - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TMO - 1);

  localparam logic [1:0] CODE_NONE  = 2'd0;
  localparam logic [1:0] CODE_FILL  = 2'd1;
  localparam logic [1:0] CODE_DRAIN = 2'd2;
  localparam logic [1:0] CODE_MULTI = 2'd3;

  typedef enum logic [3:0] {
    S_OFF, S_FILL, S_HOLD, S_AGIT_FWD, S_DEAD_F, S_AGIT_REV,
    S_DEAD_R, S_DRAIN, S_SPIN, S_STOP, S_FAULT
  } state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       flags, entry_flags;
  logic             active, multi, phase_exit;
  logic [1:0]       next_code;

  logic inlet_d, drain_d, fwd_d, rev_d, fast_d, lock_d, fault_d;
  logic [1:0] code_d;

  assign flags  = {soak_op, wash_op, rinse_op, spin_op};
  assign active = |flags;
  // More than one bit set: clearing the lowest set bit leaves something.
  assign multi  = (flags & (flags - 4'd1)) != 4'd0;
  // The phase that started this run must remain the only one asserted.
  assign phase_exit = (flags != entry_flags);

  // State register and registered Moore outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_OFF;
      inlet_valve <= 1'b0;
      drain_valve <= 1'b0;
      motor_fwd   <= 1'b0;
      motor_rev   <= 1'b0;
      motor_fast  <= 1'b0;
      door_lock   <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= CODE_NONE;
    end else begin
      state       <= next_state;
      inlet_valve <= inlet_d;
      drain_valve <= drain_d;
      motor_fwd   <= fwd_d;
      motor_rev   <= rev_d;
      motor_fast  <= fast_d;
      door_lock   <= lock_d;
      fault       <= fault_d;
      fault_code  <= code_d;
    end
  end

  // Remember which phase flags were present when the run left OFF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_flags <= 4'd0;
    end else if (state == S_OFF) begin
      entry_flags <= flags;
    end
  end

  // Shared dwell counter: zero on every state entry, saturating while resident.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (next_state != state) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Next-state selection in priority order: multi-phase, lid, timeout, phase exit, normal.
  always_comb begin
    next_state = state;
    next_code  = fault_code;
    if (state == S_FAULT) begin
      if (fault_clr && !active) begin
        next_state = S_OFF;
      end
    end else if (multi) begin
      next_state = S_FAULT;
      next_code  = CODE_MULTI;
    end else if (state == S_OFF) begin
      if (!lid) begin
        if (water_inlet && !level_full) begin
          next_state = S_FILL;
        end else if (soak_op && level_full) begin
          next_state = S_HOLD;
        end else if (wash_op || rinse_op) begin
          next_state = S_AGIT_FWD;
        end else if (spin_op) begin
          next_state = S_DRAIN;
        end
      end
    end else if (lid && state != S_STOP) begin
      // STOP is already the run-down path, so an open lid lets it finish.
      next_state = S_STOP;
    end else if (state == S_FILL && !level_full && cnt == FILL_LAST) begin
      next_state = S_FAULT;
      next_code  = CODE_FILL;
    end else if (state == S_DRAIN && !level_empty && cnt == DRAIN_LAST) begin
      next_state = S_FAULT;
      next_code  = CODE_DRAIN;
    end else if (state != S_STOP && phase_exit) begin
      next_state = S_STOP;
    end else begin
      unique case (state)
        S_FILL: begin
          if (level_full) begin
            if (soak_op) begin
              next_state = S_HOLD;
            end else if (wash_op || rinse_op) begin
              next_state = S_AGIT_FWD;
            end else begin
              // Filled with no phase that uses water: run down safely.
              next_state = S_STOP;
            end
          end
        end
        S_AGIT_FWD: if (cnt == ON_LAST)   next_state = S_DEAD_F;
        S_DEAD_F:   if (cnt == DEAD_LAST) next_state = S_AGIT_REV;
        S_AGIT_REV: if (cnt == ON_LAST)   next_state = S_DEAD_R;
        S_DEAD_R:   if (cnt == DEAD_LAST) next_state = S_AGIT_FWD;
        S_DRAIN:    if (level_empty)      next_state = S_SPIN;
        S_STOP:     if (cnt == DEAD_LAST) next_state = S_OFF;
        S_HOLD, S_SPIN: next_state = state;
        default:    next_state = S_OFF;
      endcase
    end
  end

  // Output decode of the state being entered; registered above.
  always_comb begin
    inlet_d = 1'b0;
    drain_d = 1'b0;
    fwd_d   = 1'b0;
    rev_d   = 1'b0;
    fast_d  = 1'b0;
    lock_d  = 1'b0;
    fault_d = 1'b0;
    code_d  = CODE_NONE;
    unique case (next_state)
      S_OFF: ;
      S_FILL: begin
        inlet_d = 1'b1;
        lock_d  = 1'b1;
      end
      S_HOLD, S_DEAD_F, S_DEAD_R, S_STOP: lock_d = 1'b1;
      S_AGIT_FWD: begin
        fwd_d  = 1'b1;
        lock_d = 1'b1;
      end
      S_AGIT_REV: begin
        rev_d  = 1'b1;
        lock_d = 1'b1;
      end
      S_DRAIN: begin
        drain_d = 1'b1;
        lock_d  = 1'b1;
      end
      S_SPIN: begin
        fwd_d   = 1'b1;
        fast_d  = 1'b1;
        drain_d = 1'b1;
        lock_d  = 1'b1;
      end
      S_FAULT: begin
        drain_d = 1'b1;
        fault_d = 1'b1;
        code_d  = next_code;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/wm_drive_sequencer.md
Name: wm_drive_sequencer

Overview:
- Downstream actuator stage of the washing machine controller.
- Consumes the controller's one-hot phase flags (soak_op, wash_op, rinse_op, spin_op) and water_inlet, plus the lid and water-level sensors.
- Drives the inlet valve, drain valve, motor direction/speed and door lock, with agitation patterns, dead-time between motor reversals, fill/drain timeouts and a latched fault.

Parameters:
AGIT_ON, 4, cycles per forward or reverse agitation burst (>=1)
AGIT_DEAD, 2, motor-off cycles between any direction change and on phase exit (>=1)
FILL_TMO, 20, max cycles in FILL before fault
DRAIN_TMO, 20, max cycles in DRAIN before fault

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
soak_op  in  1  controller in SOAK
wash_op  in  1  controller in WASH
rinse_op  in  1  controller in RINSE
spin_op  in  1  controller in SPIN
water_inlet  in  1  controller requests water
lid  in  1  1 = lid open
level_full  in  1  drum at fill level
level_empty  in  1  drum empty
fault_clr  in  1  clears latched fault
inlet_valve  out  1  open inlet valve
drain_valve  out  1  open drain valve
motor_fwd  out  1  motor forward
motor_rev  out  1  motor reverse
motor_fast  out  1  spin speed select
door_lock  out  1  lock engaged
fault  out  1  fault latched
fault_code  out  2  0 none, 1 fill timeout, 2 drain timeout, 3 multiple phase flags

Behaviour:
- Clock and reset: single clock clk; asynchronous active-low reset rst_n. Reset forces state OFF, counters 0 and every output 0.
- Output timing: all outputs are registered Moore decodes of the state. Each response appears on the edge after the qualifying input is sampled.
- Phase decode: active = soak_op|wash_op|rinse_op|spin_op. More than one flag high is an error (multi-phase).
- Transition priority: multi-phase (to FAULT, code 3) > lid=1 > timeout > phase exit > normal transition.
- States and outputs:
  - OFF: all outputs 0.
    - Goes to FILL if water_inlet && !level_full.
    - Else goes to HOLD if soak_op && level_full.
    - Else goes to AGIT_FWD if wash_op|rinse_op.
    - Else goes to DRAIN if spin_op.
  - FILL: inlet_valve=1, door_lock=1.
    - On level_full: goes to HOLD if soak_op, AGIT_FWD if wash/rinse.
  - HOLD: door_lock=1 only.
  - AGIT_FWD: motor_fwd=1, door_lock=1, for exactly AGIT_ON cycles, then DEAD_F.
  - DEAD_F: door_lock=1, motor off, for AGIT_DEAD cycles, then AGIT_REV.
  - AGIT_REV: motor_rev=1, door_lock=1, for AGIT_ON cycles, then DEAD_R.
  - DEAD_R: door_lock=1, motor off, for AGIT_DEAD cycles, then AGIT_FWD. The agitation pattern repeats indefinitely.
  - DRAIN: drain_valve=1, door_lock=1. On level_empty goes to SPIN.
  - SPIN: motor_fwd=1, motor_fast=1, drain_valve=1, door_lock=1.
  - STOP: door_lock=1, all else 0, for AGIT_DEAD cycles, then OFF.
  - FAULT: drain_valve=1 (safety drain), fault=1, fault_code held, all else 0. door_lock=0.
    - Exits to OFF only when fault_clr=1 && active=0. fault_clr while any phase flag is active is ignored.
- Phase exit: in any non-OFF, non-FAULT state, if the flag that caused entry drops or a different flag rises, go to STOP. This applies to FILL and HOLD as well, so the motor always sees AGIT_DEAD off-cycles before restarting.
- Lid: lid=1 in any non-OFF, non-FAULT state forces STOP, then OFF. OFF does not leave while lid=1.
- Interlocks: motor_fwd and motor_rev are never both 1. Every direction change passes through a dead state. motor_fast=1 only in SPIN.
- Counters:
  - One shared dwell counter, width $clog2(max(AGIT_ON, AGIT_DEAD, FILL_TMO, DRAIN_TMO)+1).
  - Cleared on every state entry, increments each cycle in the state.
  - Dwell states leave when counter == param-1.
- Timeouts:
  - FILL with !level_full at counter == FILL_TMO-1 goes to FAULT, code 1. FAULT is entered FILL_TMO cycles after FILL entry.
  - DRAIN works the same way with DRAIN_TMO, code 2.
  - level_full or level_empty arriving on the final cycle wins over the timeout.
- Reset mid-operation: immediate return to OFF with outputs 0. A fault is not retained across reset.

Test Plan:
- Reset with all inputs 0 -> all outputs 0, state OFF; release rst_n -> stays OFF.
- rinse_op=1, water_inlet=1, level_full rises 5 cycles after FILL entry -> inlet_valve=1 for 5 cycles, then motor_fwd 4 cycles, off 2, motor_rev 4, off 2, repeating; fwd&rev never both 1.
- soak_op=1, water_inlet=1, level_full held 0 -> inlet_valve=1 exactly 20 cycles, then fault=1, fault_code=1, drain_valve=1, door_lock=0. fault_clr with soak_op=1 -> no change. fault_clr with flags 0 -> OFF.
- spin_op=1, level_empty after 3 cycles -> drain_valve 3 cycles, then motor_fwd=motor_fast=drain_valve=1. spin_op drops -> 2 cycles all motor off with door_lock=1, then OFF.
- wash_op=1 in AGIT_FWD cycle 2, then lid=1 -> next edge motor_fwd=0, STOP 2 cycles, OFF. Remains OFF while lid=1.
- wash_op=1 and spin_op=1 together -> FAULT, fault_code=3, on the next edge. Async rst_n pulse mid-SPIN -> outputs 0 immediately, without waiting for a clock edge.
